// File: rtl/vram_scanout.sv
// vram_scanout -- VGA-style scanout engine for a 1bpp framebuffer held in VRAM.
//
// Generates horizontal/vertical timing from two free-running counters. It fetches
// 16-pixel framebuffer words over the registered-address VRAM read port. It then
// serialises them MSB-first into a pixel stream, with every FB pixel drawn
// SCALE x SCALE.
//
// Output alignment:
//   Every output appears exactly three enabled cycles after the counter position
//   it describes. This covers pixel, sync, blank and frame_start, so all of them
//   stay mutually aligned.
//
// Ports:
//   clk          pixel clock (also drives the bram VRAM port)
//   rst          asynchronous active-high reset
//   en           1 = run, 0 = freeze all internal state and outputs
//   vaddr[15:0]  VRAM word address towards the bram
//   vout[15:0]   VRAM read data, valid one cycle after vaddr is captured
//   hsync_n      horizontal sync, active low
//   vsync_n      vertical sync, active low
//   blank        1 outside the visible area
//   pixel        current pixel, 0 when blanked or outside the framebuffer
//   frame_start  one-cycle pulse coincident with output pixel (0,0)
module vram_scanout #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned FB_W      = 128,
  parameter int unsigned FB_H      = 64,
  parameter int unsigned SCALE     = 5,
  parameter logic [15:0] VRAM_BASE = 16'hC000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] vaddr,
  input  logic [15:0] vout,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        blank,
  output logic        pixel,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  // +1 keeps the phase counter at least one bit wide when SCALE == 1
  localparam int unsigned SW      = $clog2(SCALE + 32'd1);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 32'd1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 32'd1);
  localparam logic [SW-1:0] SC_LAST = SW'(SCALE - 32'd1);

  // Per-position timing flags carried down the three pipeline stages.
  typedef struct packed {
    logic vis;  // visible area
    logic hs;   // hsync active
    logic vs;   // vsync active
    logic fb;   // inside framebuffer region
    logic fs;   // frame start (0,0)
    logic ld;   // a framebuffer word fetch was issued for this position
  } stg_t;

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [15:0]   vaddr_q, vaddr_d;
  stg_t          s1_q, s1_d, s2_q, s2_d;
  logic [15:0]   shreg_q, shreg_d;
  logic [SW-1:0] sc_q, sc_d;
  logic          hsync_n_q, hsync_n_d;
  logic          vsync_n_q, vsync_n_d;
  logic          blank_q, blank_d;
  logic          pixel_q, pixel_d;
  logic          fs_q, fs_d;

  logic [31:0]   h32_s, v32_s, fx_s, fy_s, off_s;
  stg_t          s0_s;

  // Counter-stage timing decode and fetch address computation.
  always_comb begin
    h32_s   = 32'(hcnt_q);
    v32_s   = 32'(vcnt_q);
    fx_s    = h32_s / SCALE;
    fy_s    = v32_s / SCALE;
    off_s   = fy_s * (FB_W / 32'd16) + fx_s / 32'd16;
    s0_s.vis = (h32_s < H_ACTIVE) && (v32_s < V_ACTIVE);
    s0_s.hs  = (h32_s >= H_ACTIVE + H_FP) && (h32_s < H_ACTIVE + H_FP + H_SYNC);
    s0_s.vs  = (v32_s >= V_ACTIVE + V_FP) && (v32_s < V_ACTIVE + V_FP + V_SYNC);
    s0_s.fb  = (h32_s < FB_W * SCALE) && (v32_s < FB_H * SCALE);
    s0_s.fs  = (hcnt_q == '0) && (vcnt_q == '0);
    s0_s.ld  = s0_s.fb && ((h32_s % (32'd16 * SCALE)) == 32'd0);
  end

  // Next-state logic: counters, fetch address, pipeline, serialiser, outputs.
  always_comb begin
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    vaddr_d   = vaddr_q;
    s1_d      = s1_q;
    s2_d      = s2_q;
    shreg_d   = shreg_q;
    sc_d      = sc_q;
    hsync_n_d = hsync_n_q;
    vsync_n_d = vsync_n_q;
    blank_d   = blank_q;
    pixel_d   = pixel_q;
    fs_d      = fs_q;
    if (en) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        if (vcnt_q == V_LAST) begin
          vcnt_d = '0;
        end else begin
          vcnt_d = vcnt_q + VW'(1);
        end
      end else begin
        hcnt_d = hcnt_q + HW'(1);
      end

      if (s0_s.ld) begin
        vaddr_d = VRAM_BASE + 16'(off_s);
      end else begin
        vaddr_d = vaddr_q;
      end

      s1_d = s0_s;
      s2_d = s1_q;

      // vout belongs to the word fetched two stages ago; load it, otherwise
      // advance one FB pixel every SCALE cycles.
      if (s2_q.ld) begin
        shreg_d = vout;
        sc_d    = '0;
      end else if (sc_q == SC_LAST) begin
        shreg_d = {shreg_q[14:0], 1'b0};
        sc_d    = '0;
      end else begin
        sc_d    = sc_q + SW'(1);
      end

      hsync_n_d = ~s2_q.hs;
      vsync_n_d = ~s2_q.vs;
      blank_d   = ~s2_q.vis;
      fs_d      = s2_q.fs;
      pixel_d   = shreg_d[15] & s2_q.fb & s2_q.vis;
    end else begin
      hcnt_d = hcnt_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      vaddr_q   <= VRAM_BASE;
      s1_q      <= '0;
      s2_q      <= '0;
      shreg_q   <= 16'h0000;
      sc_q      <= '0;
      hsync_n_q <= 1'b1;
      vsync_n_q <= 1'b1;
      blank_q   <= 1'b1;
      pixel_q   <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      vaddr_q   <= vaddr_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      shreg_q   <= shreg_d;
      sc_q      <= sc_d;
      hsync_n_q <= hsync_n_d;
      vsync_n_q <= vsync_n_d;
      blank_q   <= blank_d;
      pixel_q   <= pixel_d;
      fs_q      <= fs_d;
    end
  end

  assign vaddr       = vaddr_q;
  assign hsync_n     = hsync_n_q;
  assign vsync_n     = vsync_n_q;
  assign blank       = blank_q;
  assign pixel       = pixel_q;
  assign frame_start = fs_q;

endmodule
